// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: turns the received byte stream into per-key press/release/held events.
// Optional AUTOREPEAT_EN macro adds per-key auto-repeat timers; without it key_repeat is tied to 0.
module ps2_key_decoder #(
    parameter int                      NUM_KEYS    = 5,
    parameter logic [8*NUM_KEYS-1:0]   KEY_CODES   = {8'h29, 8'h74, 8'h6B, 8'h72, 8'h75},
    parameter logic [NUM_KEYS-1:0]     KEY_EXT     = 5'b01111,
    parameter logic [19:0]             SEQ_TIMEOUT = 20'd500000
`ifdef AUTOREPEAT_EN
    ,
    parameter logic [24:0]             REPEAT_DELAY  = 25'd25000000,
    parameter logic [24:0]             REPEAT_PERIOD = 25'd5000000
`endif
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                clear,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                unknown_code,
    output logic                seq_error,
    output logic [1:0]          fsm_state
);

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [19:0] tmo_cnt;
    logic [19:0] tmo_cnt_nxt;
    logic        tmo_hit;
    logic        code_done;
    logic        code_ext;
    logic        code_brk;

    logic [NUM_KEYS-1:0] match;
    logic [NUM_KEYS-1:0] make_hit;
    logic [NUM_KEYS-1:0] brk_hit;
    logic [NUM_KEYS-1:0] press_nxt;
    logic [NUM_KEYS-1:0] release_nxt;
    logic [NUM_KEYS-1:0] held_nxt;
    logic                unknown_nxt;

    assign fsm_state = state;

    // Prefix tracking; a received byte always wins over the timeout on the same cycle.
    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        tmo_hit     = 1'b0;
        code_done   = 1'b0;
        code_ext    = 1'b0;
        code_brk    = 1'b0;
        if (rx_valid) begin
            tmo_cnt_nxt = '0;
            case (state)
                IDLE: begin
                    if (rx_data == BYTE_EXT) begin
                        state_nxt = EXT;
                    end else if (rx_data == BYTE_BRK) begin
                        state_nxt = BRK;
                    end else begin
                        code_done = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_data == BYTE_BRK) begin
                        state_nxt = EXT_BRK;
                    end else if (rx_data != BYTE_EXT) begin
                        code_done = 1'b1;
                        code_ext  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    if (rx_data == BYTE_EXT) begin
                        state_nxt = EXT_BRK;
                    end else if (rx_data != BYTE_BRK) begin
                        code_done = 1'b1;
                        code_brk  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                EXT_BRK: begin
                    if ((rx_data != BYTE_EXT) && (rx_data != BYTE_BRK)) begin
                        code_done = 1'b1;
                        code_ext  = 1'b1;
                        code_brk  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (tmo_cnt + 20'd1 == SEQ_TIMEOUT) begin
                tmo_hit     = 1'b1;
                tmo_cnt_nxt = '0;
                state_nxt   = IDLE;
            end else begin
                tmo_cnt_nxt = tmo_cnt + 20'd1;
            end
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            match[i] = (rx_data == KEY_CODES[8*i +: 8]) && (code_ext == KEY_EXT[i]);
        end
    end

    assign make_hit    = match & {NUM_KEYS{code_done & ~code_brk}};
    assign brk_hit     = match & {NUM_KEYS{code_done &  code_brk}};
    assign press_nxt   = make_hit & ~key_held;
    assign release_nxt = brk_hit & key_held;
    assign held_nxt    = (key_held | make_hit) & ~brk_hit;
    assign unknown_nxt = code_done && (match == '0);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            key_press    <= '0;
            key_release  <= '0;
            key_held     <= '0;
            unknown_code <= 1'b0;
            seq_error    <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            key_press    <= '0;
            key_release  <= '0;
            key_held     <= '0;
            unknown_code <= 1'b0;
            seq_error    <= 1'b0;
        end else begin
            state        <= state_nxt;
            tmo_cnt      <= tmo_cnt_nxt;
            key_press    <= press_nxt;
            key_release  <= release_nxt;
            key_held     <= held_nxt;
            unknown_code <= unknown_nxt;
            seq_error    <= tmo_hit;
        end
    end

`ifdef AUTOREPEAT_EN
    logic [24:0]         rpt_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] rpt_phase;

    // Any make/break on a key restarts its timer, so a break never coincides with a repeat.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_repeat <= '0;
            rpt_phase  <= '0;
            for (int i = 0; i < NUM_KEYS; i++) rpt_cnt[i] <= '0;
        end else if (clear) begin
            key_repeat <= '0;
            rpt_phase  <= '0;
            for (int i = 0; i < NUM_KEYS; i++) rpt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_repeat[i] <= 1'b0;
                if (make_hit[i] || brk_hit[i] || !key_held[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_phase[i] <= 1'b0;
                end else if (!rpt_phase[i] && (rpt_cnt[i] + 25'd1 == REPEAT_DELAY)) begin
                    key_repeat[i] <= 1'b1;
                    rpt_cnt[i]    <= '0;
                    rpt_phase[i]  <= 1'b1;
                end else if (rpt_phase[i] && (rpt_cnt[i] + 25'd1 == REPEAT_PERIOD)) begin
                    key_repeat[i] <= 1'b1;
                    rpt_cnt[i]    <= '0;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + 25'd1;
                end
            end
        end
    end
`else
    assign key_repeat = '0;
`endif

endmodule
